fp_mul_norm_round: RTL and testbench

- Pipelined post-multiply stage of the bfloat16 floating-point multiplier (1 sign, 8 exp bias 127, 7 frac).
- Sits directly downstream of the 8x8 significand multiplier. Consumes its 16-bit product together with the operand exponents, signs and class codes.
- Adds exponents, normalizes, rounds to nearest-even and packs the final 16-bit result with IEEE-style flags.
- Two register stages with a valid/ready handshake, so the combinational multiplier can stay unregistered upstream.

---
 rtl/fp_mul_pkg.sv | 25 ++
 rtl/fp_mul_norm_round_rne.sv | 25 ++
 rtl/fp_mul_norm_round.sv | 175 +++++++++++++++++
 tb/tb_fp_mul_norm_round.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the bfloat16 multiplier post-multiply stage.
package fp_mul_pkg;

  // Operand classification supplied by the unpack logic upstream.
  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } cls_e;

  // Special-case outcome resolved in stage 1, applied in stage 2.
  typedef enum logic [1:0] {
    SP_NONE = 2'd0,
    SP_QNAN = 2'd1,
    SP_INF  = 2'd2,
    SP_ZERO = 2'd3
  } spec_e;

  localparam int          BIAS      = 127;
  localparam int          EXP_MAX   = 255;
  localparam logic [15:0] BF16_QNAN = 16'h7FC0;
  localparam logic [15:0] BF16_INF  = 16'h7F80;

endpackage

// File: rtl/fp_mul_norm_round_rne.sv
// Round-to-nearest-even on a normalized fraction with guard/sticky bits.
// A carry out of the fraction wraps it to zero and bumps the exponent.
module fp_rne_round #(
  parameter int FRAC_W = 7,
  parameter int EW     = 10
) (
  input  logic [FRAC_W-1:0] frac_i,
  input  logic              guard_i,
  input  logic              sticky_i,
  input  logic [EW-1:0]     exp_i,
  output logic [FRAC_W-1:0] frac_o,
  output logic [EW-1:0]     exp_o,
  output logic              inexact_o
);

  logic            round_up;
  logic [FRAC_W:0] frac_sum;

  assign round_up  = guard_i & (sticky_i | frac_i[0]);
  assign frac_sum  = {1'b0, frac_i} + {{FRAC_W{1'b0}}, round_up};
  assign frac_o    = frac_sum[FRAC_W-1:0];
  assign exp_o     = exp_i + {{(EW-1){1'b0}}, frac_sum[FRAC_W]};
  assign inexact_o = guard_i | sticky_i;

endmodule

// File: rtl/fp_mul_norm_round.sv
// Post-multiply stage of the bfloat16 multiplier: exponent add and
// normalize (stage 1), round/pack/flag (stage 2), valid/ready between.
module fp_mul_norm_round #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 7,
  parameter int BIAS   = fp_mul_pkg::BIAS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_sign_a,
  input  logic                      in_sign_b,
  input  logic [EXP_W-1:0]          in_exp_a,
  input  logic [EXP_W-1:0]          in_exp_b,
  input  logic [1:0]                in_cls_a,
  input  logic [1:0]                in_cls_b,
  input  logic [2*(FRAC_W+1)-1:0]   in_prod,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+FRAC_W:0]     out_result,
  output logic                      out_overflow,
  output logic                      out_underflow,
  output logic                      out_inexact
);
  import fp_mul_pkg::*;

  // Two guard bits on the exponent: one for overflow headroom, one sign.
  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * (FRAC_W + 1);
  localparam int RW = 1 + EXP_W + FRAC_W;

  logic              s1_valid_q;
  logic              s1_sign_q,   s1_sign_d;
  logic [EW-1:0]     s1_exp_q,    s1_exp_d;
  logic [FRAC_W-1:0] s1_frac_q,   s1_frac_d;
  logic              s1_guard_q,  s1_guard_d;
  logic              s1_sticky_q, s1_sticky_d;
  spec_e             s1_spec_q,   s1_spec_d;

  logic              out_valid_q;
  logic [RW-1:0]     out_result_q, out_result_d;
  logic              out_ovf_q,    out_ovf_d;
  logic              out_unf_q,    out_unf_d;
  logic              out_inx_q,    out_inx_d;

  logic              s2_open;
  logic              s1_advance;
  logic              a_zero, b_zero, a_inf, b_inf, any_nan;

  logic [FRAC_W-1:0] rnd_frac;
  logic [EW-1:0]     rnd_exp;
  logic              rnd_inexact;

  assign s2_open    = !out_valid_q | out_ready;
  assign s1_advance = s1_valid_q & s2_open;
  assign in_ready   = !s1_valid_q | s1_advance;

  assign a_zero  = (in_cls_a == CLS_ZERO);
  assign b_zero  = (in_cls_b == CLS_ZERO);
  assign a_inf   = (in_cls_a == CLS_INF);
  assign b_inf   = (in_cls_b == CLS_INF);
  assign any_nan = (in_cls_a == CLS_NAN) | (in_cls_b == CLS_NAN);

  // Stage 1 next values: biased exponent sum, one-bit normalize, special class.
  always_comb begin
    s1_sign_d = in_sign_a ^ in_sign_b;
    s1_exp_d  = {2'b00, in_exp_a} + {2'b00, in_exp_b} - EW'(BIAS)
              + {{(EW-1){1'b0}}, in_prod[PW-1]};
    if (in_prod[PW-1]) begin
      s1_frac_d   = in_prod[PW-2 -: FRAC_W];
      s1_guard_d  = in_prod[PW-FRAC_W-2];
      s1_sticky_d = |in_prod[PW-FRAC_W-3:0];
    end else begin
      s1_frac_d   = in_prod[PW-3 -: FRAC_W];
      s1_guard_d  = in_prod[PW-FRAC_W-3];
      s1_sticky_d = |in_prod[PW-FRAC_W-4:0];
    end
    if (any_nan | (a_zero & b_inf) | (a_inf & b_zero)) begin
      s1_spec_d = SP_QNAN;
    end else if (a_inf | b_inf) begin
      s1_spec_d = SP_INF;
    end else if (a_zero | b_zero) begin
      s1_spec_d = SP_ZERO;
    end else begin
      s1_spec_d = SP_NONE;
    end
  end

  fp_rne_round #(
    .FRAC_W (FRAC_W),
    .EW     (EW)
  ) u_rne (
    .frac_i    (s1_frac_q),
    .guard_i   (s1_guard_q),
    .sticky_i  (s1_sticky_q),
    .exp_i     (s1_exp_q),
    .frac_o    (rnd_frac),
    .exp_o     (rnd_exp),
    .inexact_o (rnd_inexact)
  );

  // Stage 2 next values: specials win, then overflow / flush-to-zero / pack.
  always_comb begin
    out_result_d = '0;
    out_ovf_d    = 1'b0;
    out_unf_d    = 1'b0;
    out_inx_d    = 1'b0;
    case (s1_spec_q)
      SP_QNAN: out_result_d = BF16_QNAN;
      SP_INF:  out_result_d = {s1_sign_q, BF16_INF[RW-2:0]};
      SP_ZERO: out_result_d = {s1_sign_q, {(RW-1){1'b0}}};
      default: begin
        if (!rnd_exp[EW-1] && rnd_exp >= EW'(EXP_MAX)) begin
          out_result_d = {s1_sign_q, BF16_INF[RW-2:0]};
          out_ovf_d    = 1'b1;
          out_inx_d    = 1'b1;
        end else if (rnd_exp[EW-1] || rnd_exp == '0) begin
          out_result_d = {s1_sign_q, {(RW-1){1'b0}}};
          out_unf_d    = 1'b1;
          out_inx_d    = 1'b1;
        end else begin
          out_result_d = {s1_sign_q, rnd_exp[EXP_W-1:0], rnd_frac};
          out_inx_d    = rnd_inexact;
        end
      end
    endcase
  end

  // Pipeline registers; each stage loads when its successor has room.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_exp_q     <= '0;
      s1_frac_q    <= '0;
      s1_guard_q   <= 1'b0;
      s1_sticky_q  <= 1'b0;
      s1_spec_q    <= SP_NONE;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_ovf_q    <= 1'b0;
      out_unf_q    <= 1'b0;
      out_inx_q    <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_sign_q   <= s1_sign_d;
          s1_exp_q    <= s1_exp_d;
          s1_frac_q   <= s1_frac_d;
          s1_guard_q  <= s1_guard_d;
          s1_sticky_q <= s1_sticky_d;
          s1_spec_q   <= s1_spec_d;
        end
      end
      if (s2_open) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_result_q <= out_result_d;
          out_ovf_q    <= out_ovf_d;
          out_unf_q    <= out_unf_d;
          out_inx_q    <= out_inx_d;
        end
      end
    end
  end

  assign out_valid     = out_valid_q;
  assign out_result    = out_result_q;
  assign out_overflow  = out_ovf_q;
  assign out_underflow = out_unf_q;
  assign out_inexact   = out_inx_q;

endmodule

// File: tb/tb_fp_mul_norm_round.sv
// Bench for fp_mul_norm_round: directed vector table, backpressure and
// reset sequences, then randomized traffic against a value-level model.
module tb_fp_mul_norm_round;
  import fp_mul_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign_a, in_sign_b;
  logic [7:0]  in_exp_a, in_exp_b;
  logic [1:0]  in_cls_a, in_cls_b;
  logic [15:0] in_prod;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        out_overflow, out_underflow, out_inexact;

  int total = 0;
  int bad   = 0;

  fp_mul_norm_round dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign_a     (in_sign_a),
    .in_sign_b     (in_sign_b),
    .in_exp_a      (in_exp_a),
    .in_exp_b      (in_exp_b),
    .in_cls_a      (in_cls_a),
    .in_cls_b      (in_cls_b),
    .in_prod       (in_prod),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow),
    .out_inexact   (out_inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sa, sb;
    logic [7:0]  ea, eb;
    logic [1:0]  ca, cb;
    logic [15:0] prod;
    logic [15:0] res;
    logic        ov, un, ix;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Value-level reference: treat the product as an integer scaled by 2^(e-14),
  // keep 8 significant bits, round the remainder to nearest-even.
  function automatic logic [18:0] model(input logic sa, input logic sb,
                                         input logic [7:0] ea, input logic [7:0] eb,
                                         input logic [1:0] ca, input logic [1:0] cb,
                                         input logic [15:0] prod);
    logic s;
    int e, sh, keep, rem, half;
    logic ix;
    s = sa ^ sb;
    if (ca == 2'd3 || cb == 2'd3 || (ca == 2'd0 && cb == 2'd2) || (ca == 2'd2 && cb == 2'd0))
      return {3'b000, 16'h7FC0};
    if (ca == 2'd2 || cb == 2'd2)
      return {3'b000, s, 15'h7F80};
    if (ca == 2'd0 || cb == 2'd0)
      return {3'b000, s, 15'h0000};
    e = int'(ea) + int'(eb) - 127;
    if (int'(prod) >= 32768) begin
      sh = 8;
      e  = e + 1;
    end else begin
      sh = 7;
    end
    keep = int'(prod) / (1 << sh);
    rem  = int'(prod) - keep * (1 << sh);
    half = 1 << (sh - 1);
    ix   = (rem != 0);
    if (rem > half || (rem == half && (keep % 2) == 1)) keep = keep + 1;
    if (keep == 256) begin
      keep = 128;
      e    = e + 1;
    end
    if (e >= 255) return {3'b101, s, 15'h7F80};
    if (e <= 0)   return {3'b011, s, 15'h0000};
    return {2'b00, ix, s, 8'(e), 7'(keep - 128)};
  endfunction

  // Scoreboard state
  logic [18:0] exp_q[$];
  bit          sb_en = 0;
  bit          hold_pending = 0;
  logic [18:0] held;
  bit          saw_block = 0;
  int          n_out = 0;

  // Monitor: samples just after the falling edge; records accepted inputs,
  // checks drained outputs in order and held outputs for stability.
  always @(negedge clk) begin
    #1;
    if (sb_en && rst_n) begin
      if (hold_pending) begin
        chk("hold_valid", {31'b0, out_valid}, 32'd1);
        chk("hold_value", {13'b0, out_overflow, out_underflow, out_inexact, out_result},
            {13'b0, held});
      end
      if (in_valid && !in_ready) saw_block = 1;
      if (in_valid && in_ready)
        exp_q.push_back(model(in_sign_a, in_sign_b, in_exp_a, in_exp_b, in_cls_a, in_cls_b, in_prod));
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL stream_extra: got %h want none", out_result);
        end else begin
          chk("stream", {13'b0, out_overflow, out_underflow, out_inexact, out_result},
              {13'b0, exp_q.pop_front()});
        end
      end
      hold_pending = out_valid && !out_ready;
      held = {out_overflow, out_underflow, out_inexact, out_result};
    end else begin
      hold_pending = 0;
    end
  end

  task automatic set_in(input logic sa, input logic sb, input logic [7:0] ea, input logic [7:0] eb,
                        input logic [1:0] ca, input logic [1:0] cb, input logic [15:0] prod);
    in_sign_a = sa; in_sign_b = sb;
    in_exp_a  = ea; in_exp_b  = eb;
    in_cls_a  = ca; in_cls_b  = cb;
    in_prod   = prod;
  endtask

  // Present one input from a falling edge and hold it until accepted.
  task automatic push(input logic sa, input logic sb, input logic [7:0] ea, input logic [7:0] eb,
                      input logic [1:0] ca, input logic [1:0] cb, input logic [15:0] prod);
    bit done;
    done = 0;
    set_in(sa, sb, ea, eb, ca, cb, prod);
    in_valid = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      #1;
      done = in_ready;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL push_timeout: got in_ready 0 want 1");
    end
  endtask

  task automatic push_rand();
    int ma, mb, r;
    logic [1:0] ca, cb;
    ma = $urandom_range(128, 255);
    mb = $urandom_range(128, 255);
    r  = $urandom_range(0, 15);
    ca = (r == 0) ? 2'd0 : (r == 1) ? 2'd2 : (r == 2) ? 2'd3 : 2'd1;
    r  = $urandom_range(0, 15);
    cb = (r == 0) ? 2'd0 : (r == 1) ? 2'd2 : (r == 2) ? 2'd3 : 2'd1;
    push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         8'($urandom_range(30, 220)), 8'($urandom_range(30, 220)),
         ca, cb, 16'(ma * mb));
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget && exp_q.size() != 0; k++) @(negedge clk);
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int base;
    //          sa  sb  ea   eb   ca cb  prod      res       ov un ix
    vecs[0]  = '{0, 0, 127, 127, 1, 1, 16'h4000, 16'h3F80, 0, 0, 0};
    vecs[1]  = '{0, 0, 127, 127, 1, 1, 16'h9000, 16'h4010, 0, 0, 0};
    vecs[2]  = '{0, 0, 127, 127, 1, 1, 16'h60C0, 16'h3FC2, 0, 0, 1};
    vecs[3]  = '{0, 0, 127, 127, 1, 1, 16'h6240, 16'h3FC4, 0, 0, 1};
    vecs[4]  = '{0, 0, 254, 254, 1, 1, 16'h4000, 16'h7F80, 1, 0, 1};
    vecs[5]  = '{0, 0,   1,   1, 1, 1, 16'h4000, 16'h0000, 0, 1, 1};
    vecs[6]  = '{0, 0, 127, 127, 0, 2, 16'h4000, 16'h7FC0, 0, 0, 0};
    vecs[7]  = '{1, 0, 127, 127, 2, 1, 16'h4000, 16'hFF80, 0, 0, 0};
    vecs[8]  = '{1, 1, 127, 127, 3, 1, 16'h4000, 16'h7FC0, 0, 0, 0};
    vecs[9]  = '{0, 1, 127, 127, 0, 1, 16'h4000, 16'h8000, 0, 0, 0};
    vecs[10] = '{0, 0, 127, 127, 1, 1, 16'h7FC0, 16'h4000, 0, 0, 1};
    vecs[11] = '{0, 0, 127, 254, 1, 1, 16'h7FC0, 16'h7F80, 1, 0, 1};
    vecs[12] = '{0, 0, 127, 254, 1, 1, 16'h4000, 16'h7F00, 0, 0, 0};
    vecs[13] = '{0, 0,  63,  64, 1, 1, 16'h4000, 16'h0000, 0, 1, 1};
    vecs[14] = '{0, 0,  64,  64, 1, 1, 16'h4000, 16'h0080, 0, 0, 0};
    vecs[15] = '{1, 0, 127, 127, 1, 1, 16'h4000, 16'hBF80, 0, 0, 0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    set_in(0, 0, 8'd0, 8'd0, 2'd0, 2'd0, 16'h0);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", {16'b0, out_result}, 32'h0);
    chk("rst_flags", {29'b0, out_overflow, out_underflow, out_inexact}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table: one item at a time, checking the two-cycle latency.
    for (int i = 0; i < 16; i++) begin
      set_in(vecs[i].sa, vecs[i].sb, vecs[i].ea, vecs[i].eb, vecs[i].ca, vecs[i].cb, vecs[i].prod);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk($sformatf("vec%0d_lat1", i), {31'b0, out_valid}, 32'd0);
      @(negedge clk);
      #1;
      chk($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 32'd1);
      chk($sformatf("vec%0d_result", i), {16'b0, out_result}, {16'b0, vecs[i].res});
      chk($sformatf("vec%0d_flags", i), {29'b0, out_overflow, out_underflow, out_inexact},
          {29'b0, vecs[i].ov, vecs[i].un, vecs[i].ix});
      @(negedge clk);
    end

    // Backpressure: six back-to-back inputs with a four-cycle output stall.
    sb_en = 1;
    base  = n_out;
    saw_block = 0;
    fork
      begin
        push(0, 0, 127, 127, 1, 1, 16'h4000);
        push(0, 0, 127, 127, 1, 1, 16'h9000);
        push(0, 0, 127, 127, 1, 1, 16'h60C0);
        push(1, 0, 127, 127, 1, 1, 16'h6240);
        push(0, 0, 254, 254, 1, 1, 16'h4000);
        push(0, 1, 100, 130, 1, 1, 16'hA5B7);
      end
      begin
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        repeat (4) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain(50);
    chk("bp_count", 32'(n_out - base), 32'd6);
    chk("bp_in_ready_dropped", {31'b0, saw_block}, 32'd1);

    // Reset with both stages occupied, then a normal item afterwards.
    sb_en = 0;
    out_ready = 1'b0;
    push(0, 0, 127, 127, 1, 1, 16'h4000);
    push(0, 0, 127, 127, 1, 1, 16'h9000);
    #1;
    chk("full_in_ready", {31'b0, in_ready}, 32'd0);
    chk("full_result", {16'b0, out_result}, 32'h3F80);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_result", {16'b0, out_result}, 32'h0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("postrst_idle", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    set_in(0, 0, 127, 127, 1, 1, 16'h60C0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("postrst_valid", {31'b0, out_valid}, 32'd1);
    chk("postrst_result", {16'b0, out_result}, 32'h3FC2);
    @(negedge clk);
    #1;
    chk("postrst_no_dup", {31'b0, out_valid}, 32'd0);
    @(negedge clk);

    // Randomized traffic with random gaps and random downstream stalls.
    exp_q.delete();
    sb_en = 1;
    base  = n_out;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) @(negedge clk);
          push_rand();
        end
      end
      begin
        for (int c = 0; c < 1500; c++) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_any
    disable fork;
    out_ready = 1'b1;
    drain(100);
    chk("rand_count", 32'(n_out - base), 32'd300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
